nor_latch_pulse_sequencer: RTL and testbench

Clocked stimulus controller for the NOR-latch timing-evaluation structure. It drives the latch's A (reset) and B (set) inputs through their NOR funnel delay chains with programmable pulse widths and relative offsets, waits a settle interval, then samples the synchronized latch output Q. Repeats the experiment N times, streams per-trial results, and counts Q=1 outcomes for metastability/IDM characterization sweeps.

---
 rtl/nor_latch_seq_pkg.sv | 16 +
 rtl/nor_latch_q_sync.sv | 24 ++
 rtl/nor_latch_pulse_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_nor_latch_pulse_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nor_latch_seq_pkg.sv
// Shared types and defaults for the NOR-latch pulse sequencer.
package nor_latch_seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      INIT   = 3'd1,
      GAP    = 3'd2,
      PULSE  = 3'd3,
      SETTLE = 3'd4,
      SAMPLE = 3'd5,
      RESULT = 3'd6
   } state_t;

   localparam int INIT_CYC_DEF = 4;

endpackage

// File: rtl/nor_latch_q_sync.sv
// Two-flop synchronizer bringing the raw latch output into clk domain.
module nor_latch_q_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic i_q_async,
   output logic o_q_sync
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_q_async;
         r_sync <= r_meta;
      end
   end

   assign o_q_sync = r_sync;

endmodule

// File: rtl/nor_latch_pulse_sequencer.sv
// Drives A/B funnel pulses into the NOR latch, samples Q after settling,
// streams per-trial results and counts Q=1 outcomes.
//
// state  | meaning
// IDLE   | waiting for configuration
// INIT   | stim_a held high to force Q=0
// GAP    | both stim low, pre-pulse settle
// PULSE  | A/B pulses generated from phase counter t
// SETTLE | both stim low, latch resolves
// SAMPLE | capture synchronized Q, update ones count
// RESULT | present result, wait for res_ready
module nor_latch_pulse_sequencer
   import nor_latch_seq_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter int NUM_W    = 16,
   parameter int INIT_CYC = INIT_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_width_a,
   input  logic [CNT_W-1:0] cfg_gap_b,
   input  logic [CNT_W-1:0] cfg_width_b,
   input  logic [CNT_W-1:0] cfg_settle,
   input  logic [NUM_W-1:0] cfg_repeat,
   input  logic             abort,
   output logic             stim_a,
   output logic             stim_b,
   input  logic             q_async,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_q,
   output logic [NUM_W-1:0] res_idx,
   output logic [NUM_W-1:0] ones_cnt,
   output logic             busy,
   output logic             done
);

   localparam int PW = CNT_W + 1;
   localparam logic [PW-1:0]    ONE_P = PW'(1);
   localparam logic [NUM_W-1:0] ONE_N = NUM_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [PW-1:0]    r_cnt;
   logic [PW-1:0]    w_cnt_nxt;
   logic             w_load;

   logic [CNT_W-1:0] r_width_a;
   logic [CNT_W-1:0] r_gap_b;
   logic [CNT_W-1:0] r_width_b;
   logic [CNT_W-1:0] r_settle;
   logic [NUM_W-1:0] r_repeat;
   logic [NUM_W-1:0] r_res_idx;
   logic [NUM_W-1:0] r_ones_cnt;

   logic r_stim_a;
   logic r_stim_b;
   logic r_res_valid;
   logic r_res_q;
   logic r_done;
   logic r_busy;
   logic r_cfg_ready;

   logic          w_q_sync;
   logic [PW-1:0] w_a_end;
   logic [PW-1:0] w_b_start;
   logic [PW-1:0] w_b_end;
   logic [PW-1:0] w_len;
   logic          w_accept;
   logic          w_last;
   logic          w_abort;
   state_t        w_after_pulse;
   state_t        w_after_gap;
   state_t        w_after_init;
   logic          w_stim_a_nxt;
   logic          w_stim_b_nxt;

   nor_latch_q_sync u_q_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_q_async (q_async),
      .o_q_sync  (w_q_sync)
   );

   // B end is formed one bit wider so 255+255 does not wrap.
   assign w_a_end   = {1'b0, r_width_a};
   assign w_b_start = {1'b0, r_gap_b};
   assign w_b_end   = w_b_start + {1'b0, r_width_b};
   assign w_len     = (w_a_end > w_b_end) ? w_a_end : w_b_end;

   assign w_accept = cfg_valid && r_cfg_ready;
   assign w_last   = (r_res_idx == (r_repeat - ONE_N));
   assign w_abort  = abort && (r_state != IDLE);

   // Zero-length phases are skipped by chaining the successor choice.
   assign w_after_pulse = (r_settle != '0) ? SETTLE : SAMPLE;
   assign w_after_gap   = (w_len != '0) ? PULSE : w_after_pulse;
   assign w_after_init  = (r_settle != '0) ? GAP : w_after_gap;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_load      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept && (cfg_repeat != '0)) begin
               w_state_nxt = INIT;
               w_load      = 1'b1;
            end
         end
         INIT: begin
            if (r_cnt == '0) begin
               w_state_nxt = w_after_init;
               w_load      = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - ONE_P;
            end
         end
         GAP: begin
            if (r_cnt == '0) begin
               w_state_nxt = w_after_gap;
               w_load      = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - ONE_P;
            end
         end
         PULSE: begin
            if (r_cnt == (w_len - ONE_P)) begin
               w_state_nxt = w_after_pulse;
               w_load      = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + ONE_P;
            end
         end
         SETTLE: begin
            if (r_cnt == '0) begin
               w_state_nxt = SAMPLE;
               w_load      = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - ONE_P;
            end
         end
         SAMPLE: begin
            w_state_nxt = RESULT;
            w_load      = 1'b1;
         end
         RESULT: begin
            if (res_ready) begin
               w_state_nxt = w_last ? IDLE : INIT;
               w_load      = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_load      = 1'b1;
         end
      endcase

      if (w_abort) begin
         w_state_nxt = IDLE;
         w_load      = 1'b1;
      end

      if (w_load) begin
         case (w_state_nxt)
            INIT:        w_cnt_nxt = PW'(INIT_CYC - 1);
            GAP, SETTLE: w_cnt_nxt = {1'b0, r_settle} - ONE_P;
            default:     w_cnt_nxt = '0;
         endcase
      end
   end

   // Stim is computed for the state being entered so it aligns with it.
   assign w_stim_a_nxt = (w_state_nxt == INIT) ||
                         ((w_state_nxt == PULSE) && (w_cnt_nxt < w_a_end));
   assign w_stim_b_nxt = (w_state_nxt == PULSE) &&
                         (w_cnt_nxt >= w_b_start) && (w_cnt_nxt < w_b_end);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_stim_a    <= 1'b0;
         r_stim_b    <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_q     <= 1'b0;
         r_res_idx   <= '0;
         r_ones_cnt  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_cfg_ready <= 1'b1;
         r_width_a   <= '0;
         r_gap_b     <= '0;
         r_width_b   <= '0;
         r_settle    <= '0;
         r_repeat    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_stim_a    <= w_stim_a_nxt;
         r_stim_b    <= w_stim_b_nxt;
         r_res_valid <= (w_state_nxt == RESULT);
         r_busy      <= (w_state_nxt != IDLE);
         r_cfg_ready <= (w_state_nxt == IDLE);
         r_done      <= 1'b0;

         if ((r_state == IDLE) && w_accept) begin
            r_width_a  <= cfg_width_a;
            r_gap_b    <= cfg_gap_b;
            r_width_b  <= cfg_width_b;
            r_settle   <= cfg_settle;
            r_repeat   <= cfg_repeat;
            r_res_idx  <= '0;
            r_ones_cnt <= '0;
            r_done     <= (cfg_repeat == '0);
         end

         if ((r_state == SAMPLE) && !abort) begin
            r_res_q <= w_q_sync;
            if (w_q_sync && (r_ones_cnt != '1)) begin
               r_ones_cnt <= r_ones_cnt + ONE_N;
            end
         end

         if ((r_state == RESULT) && res_ready && !abort) begin
            if (w_last) begin
               r_done <= 1'b1;
            end else begin
               r_res_idx <= r_res_idx + ONE_N;
            end
         end
      end
   end

   assign cfg_ready = r_cfg_ready;
   assign stim_a    = r_stim_a;
   assign stim_b    = r_stim_b;
   assign res_valid = r_res_valid;
   assign res_q     = r_res_q;
   assign res_idx   = r_res_idx;
   assign ones_cnt  = r_ones_cnt;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_nor_latch_pulse_sequencer.sv
// Bench for the NOR-latch pulse sequencer with a behavioural latch and a
// per-trial expected stimulus timeline.
module tb_nor_latch_pulse_sequencer;

   localparam int CNT_W    = 8;
   localparam int NUM_W    = 16;
   localparam int INIT_CYC = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [CNT_W-1:0] cfg_width_a = '0;
   logic [CNT_W-1:0] cfg_gap_b = '0;
   logic [CNT_W-1:0] cfg_width_b = '0;
   logic [CNT_W-1:0] cfg_settle = '0;
   logic [NUM_W-1:0] cfg_repeat = '0;
   logic             abort = 1'b0;
   logic             stim_a;
   logic             stim_b;
   logic             q_async = 1'b0;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic             res_q;
   logic [NUM_W-1:0] res_idx;
   logic [NUM_W-1:0] ones_cnt;
   logic             busy;
   logic             done;

   int   n_checks = 0;
   int   n_fail = 0;
   logic meta_pick = 1'b0;
   logic both_hi = 1'b0;

   nor_latch_pulse_sequencer #(
      .CNT_W    (CNT_W),
      .NUM_W    (NUM_W),
      .INIT_CYC (INIT_CYC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_width_a (cfg_width_a),
      .cfg_gap_b   (cfg_gap_b),
      .cfg_width_b (cfg_width_b),
      .cfg_settle  (cfg_settle),
      .cfg_repeat  (cfg_repeat),
      .abort       (abort),
      .stim_a      (stim_a),
      .stim_b      (stim_b),
      .q_async     (q_async),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_q       (res_q),
      .res_idx     (res_idx),
      .ones_cnt    (ones_cnt),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // NOR SR latch: A resets, B sets, simultaneous release resolves to meta_pick.
   always @(negedge clk) begin
      if (stim_a && stim_b) begin
         q_async = 1'b0;
         both_hi = 1'b1;
      end else if (stim_a) begin
         q_async = 1'b0;
         both_hi = 1'b0;
      end else if (stim_b) begin
         q_async = 1'b1;
         both_hi = 1'b0;
      end else begin
         if (both_hi) q_async = meta_pick;
         both_hi = 1'b0;
      end
   end

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Latch outcome from pulse end times: whichever input releases last wins.
   function automatic logic exp_latch(input int wa, input int gb, input int wb, input logic meta);
      if (wb == 0) return 1'b0;
      if (wa == 0) return 1'b1;
      if (gb + wb > wa) return 1'b1;
      if (gb + wb < wa) return 1'b0;
      return meta;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk_eq({tag, ".stim_a"}, stim_a, 1'b0);
      chk_eq({tag, ".stim_b"}, stim_b, 1'b0);
      chk_eq({tag, ".res_valid"}, res_valid, 1'b0);
      chk_eq({tag, ".res_q"}, res_q, 1'b0);
      chk_eq({tag, ".res_idx"}, res_idx, 0);
      chk_eq({tag, ".ones_cnt"}, ones_cnt, 0);
      chk_eq({tag, ".busy"}, busy, 1'b0);
      chk_eq({tag, ".done"}, done, 1'b0);
      chk_eq({tag, ".cfg_ready"}, cfg_ready, 1'b1);
   endtask

   // mode: 0 normal, 1 abort, 2 reset at (k_trial, k_cyc) of the timeline.
   task automatic run_cfg(input int wa, input int gb, input int wb, input int st,
                          input int rep, input int bp, input int mode,
                          input int k_trial, input int k_cyc);
      logic [1:0] tl[$];
      int         len;
      int         ones;
      logic       eq;
      chk_eq("idle.cfg_ready", cfg_ready, 1'b1);
      chk_eq("idle.busy", busy, 1'b0);
      cfg_width_a = CNT_W'(wa);
      cfg_gap_b   = CNT_W'(gb);
      cfg_width_b = CNT_W'(wb);
      cfg_settle  = CNT_W'(st);
      cfg_repeat  = NUM_W'(rep);
      cfg_valid   = 1'b1;
      step();
      cfg_valid   = 1'b0;
      cfg_width_a = CNT_W'($urandom);
      cfg_gap_b   = CNT_W'($urandom);
      cfg_width_b = CNT_W'($urandom);
      cfg_settle  = CNT_W'($urandom);
      cfg_repeat  = NUM_W'($urandom);
      if (rep == 0) begin
         chk_eq("rep0.done", done, 1'b1);
         chk_eq("rep0.busy", busy, 1'b0);
         chk_eq("rep0.stim_a", stim_a, 1'b0);
         chk_eq("rep0.stim_b", stim_b, 1'b0);
         step();
         chk_eq("rep0.done_off", done, 1'b0);
         chk_eq("rep0.busy_off", busy, 1'b0);
         return;
      end
      ones = 0;
      len  = (wa > gb + wb) ? wa : gb + wb;
      for (int i = 0; i < rep; i++) begin
         meta_pick = 1'($urandom);
         tl.delete();
         for (int c = 0; c < INIT_CYC; c++) tl.push_back(2'b10);
         for (int c = 0; c < st; c++) tl.push_back(2'b00);
         for (int t = 0; t < len; t++)
            tl.push_back({(t < wa), (t >= gb) && (t < gb + wb)});
         for (int c = 0; c < st; c++) tl.push_back(2'b00);
         tl.push_back(2'b00);
         for (int c = 0; c < tl.size(); c++) begin
            if (mode != 0 && i == k_trial && c == k_cyc) begin
               if (mode == 1) begin
                  abort = 1'b1;
                  step();
                  abort = 1'b0;
                  cfg_valid = 1'b0;
                  chk_eq("abort.busy", busy, 1'b0);
                  chk_eq("abort.stim_a", stim_a, 1'b0);
                  chk_eq("abort.stim_b", stim_b, 1'b0);
                  chk_eq("abort.res_valid", res_valid, 1'b0);
                  chk_eq("abort.done", done, 1'b0);
                  chk_eq("abort.res_idx", res_idx, i);
                  chk_eq("abort.ones_cnt", ones_cnt, ones);
                  chk_eq("abort.cfg_ready", cfg_ready, 1'b1);
                  step();
                  chk_eq("abort.done_later", done, 1'b0);
               end else begin
                  cfg_valid = 1'b0;
                  rst_n = 1'b0;
                  #1;
                  chk_reset_vals("midrst");
                  @(negedge clk);
                  rst_n = 1'b1;
                  step();
               end
               return;
            end
            chk_eq("stim_a", stim_a, tl[c][1]);
            chk_eq("stim_b", stim_b, tl[c][0]);
            chk_eq("run.res_valid", res_valid, 1'b0);
            chk_eq("run.busy", busy, 1'b1);
            chk_eq("run.done", done, 1'b0);
            cfg_valid = 1'($urandom);
            step();
         end
         cfg_valid = 1'b0;
         eq = exp_latch(wa, gb, wb, meta_pick);
         ones += int'(eq);
         chk_eq("res.valid", res_valid, 1'b1);
         chk_eq("res.q", res_q, eq);
         chk_eq("res.idx", res_idx, i);
         chk_eq("res.ones_cnt", ones_cnt, ones);
         for (int b = 0; b < bp; b++) begin
            step();
            chk_eq("bp.valid", res_valid, 1'b1);
            chk_eq("bp.q", res_q, eq);
            chk_eq("bp.idx", res_idx, i);
            chk_eq("bp.stim_a", stim_a, 1'b0);
            chk_eq("bp.stim_b", stim_b, 1'b0);
         end
         res_ready = 1'b1;
         step();
         res_ready = 1'b0;
         if (i == rep - 1) begin
            chk_eq("last.done", done, 1'b1);
            chk_eq("last.busy", busy, 1'b0);
            chk_eq("last.res_valid", res_valid, 1'b0);
            chk_eq("last.ones_cnt", ones_cnt, ones);
            step();
            chk_eq("last.done_off", done, 1'b0);
         end else begin
            chk_eq("next.done", done, 1'b0);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk_reset_vals("post_reset");

      abort = 1'b1;
      step();
      abort = 1'b0;
      chk_eq("idle_abort.busy", busy, 1'b0);
      chk_eq("idle_abort.cfg_ready", cfg_ready, 1'b1);

      run_cfg(3, 5, 3, 8, 1, 0, 0, -1, -1);
      run_cfg(4, 0, 4, 8, 1, 0, 0, -1, -1);
      run_cfg(6, 2, 0, 8, 3, 0, 0, -1, -1);
      run_cfg(3, 5, 3, 4, 2, 10, 0, -1, -1);
      run_cfg(6, 2, 6, 3, 5, 0, 1, 1, INIT_CYC + 3 + 2);
      run_cfg(3, 5, 3, 8, 2, 0, 2, 1, INIT_CYC + 8 + 8 + 3);
      run_cfg(5, 5, 5, 5, 0, 0, 0, -1, -1);
      run_cfg(255, 255, 255, 2, 1, 0, 0, -1, -1);
      run_cfg(0, 0, 0, 2, 1, 1, 0, -1, -1);
      run_cfg(0, 3, 2, 2, 1, 0, 0, -1, -1);

      for (int r = 0; r < 8; r++) begin
         run_cfg($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12),
                 $urandom_range(2, 6), $urandom_range(1, 3), $urandom_range(0, 3),
                 0, -1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
